piece_spawner: RTL and testbench
================================

Name: piece_spawner

Overview:
- Parametrised, sequential successor to the combinational spawn-coordinate table.
- Owns piece generation for the Tetris board: a 7-bag randomiser driven by an LFSR, a preview queue of upcoming shapes, registered spawn coordinates for all four cells, and a top-out (game-over) check against the board's spawn rows.
- Sits between the game FSM (which requests spawns) and the board/piece-movement logic (which consumes coordinates).

Parameters:
- BOARD_W, 20, board width in cells; X_W = $clog2(BOARD_W).
- Y_W, 6, row coordinate width.
- SPAWN_X, 8, leftmost column of the 4-wide spawn box; must satisfy SPAWN_X+3 < BOARD_W.
- PREVIEW, 3, preview queue depth, 1..4.
- LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit LFSR.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- spawn_req  in  1  request next piece; accepted only when spawn_ready=1
- top_rows  in  3*BOARD_W  occupancy of rows 0..2; bit r*BOARD_W+x = cell (x,r)
- spawn_ready  out  1  block can accept spawn_req
- spawn_valid  out  1  one-cycle pulse: new piece on outputs
- shape  out  3  spawned shape 0..6
- orientation  out  2  always 0 on spawn
- x0,x1,x2,x3  out  X_W  cell columns
- y0,y1,y2,y3  out  Y_W  cell rows
- preview  out  3*PREVIEW  upcoming shapes; [2:0] is next
- game_over  out  1  sticky top-out flag

Behaviour:
- Reset (async, Reset_n=0): all outputs 0, LFSR=LFSR_SEED, bag mask=0, queue empty, state=FILL.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle except in reset.
- Draw: cand = lfsr[2:0], with 7 mapped to 0. While bag[cand]=1, set cand=(cand+1) mod 7, one probe per cycle (at most 7 cycles).
  - On an unused cand: set bag[cand] and push cand to the queue tail.
  - If the bag becomes 7'h7F, clear it to 0 in the same cycle.
- Spawn cell offsets, with C = SPAWN_X, as (x,y):
  - 0 I: (C,0)(C+1,0)(C+2,0)(C+3,0)
  - 1 O: (C+1,0)(C+2,0)(C+1,1)(C+2,1)
  - 2: (C+1,0)(C+1,1)(C+1,2)(C+2,2)
  - 3: (C+2,0)(C+2,1)(C+2,2)(C+1,2)
  - 4: (C+3,0)(C+2,0)(C+2,1)(C+1,1)
  - 5: (C+1,0)(C+2,0)(C+2,1)(C+3,1)
  - 6: (C+1,1)(C+2,1)(C+3,1)(C+2,0)
  - y values are zero-extended to Y_W.
- FSM:
  - FILL: draw until the queue holds PREVIEW entries, then go to READY.
  - READY: spawn_ready=1. On spawn_req, pop the queue head into shape/x*/y*, set orientation=0, go to CHECK.
  - CHECK (1 cycle): assert spawn_valid. If any of the 4 cells is set in top_rows, set game_over and go to OVER; otherwise go to REFILL.
  - REFILL: draw one shape, then go to READY.
  - OVER: spawn_ready=0; spawn_req is ignored. Only reset exits this state.
- Latency: spawn_req accepted in cycle N → spawn_valid in cycle N+1. Coordinates are held until the next accepted spawn.
- spawn_req while spawn_ready=0 is dropped; it is not queued.
- preview is updated on every push/pop and reflects the queue after the operation.
- Async reset mid-draw discards the partial draw and restarts FILL.
- No two consecutive 7-piece bags omit or repeat a shape within a bag.

Optional Feature:
- Macro HOLD_SLOT_EN.
- When defined, the block adds:
  - input hold_req.
  - outputs hold_shape[2:0] and hold_valid.
- Behaviour with the macro:
  - hold_req in READY, after at least one spawn, with hold not yet used since the last spawn:
    - Swap the current shape with the hold slot and reissue spawn coordinates through CHECK (spawn_valid pulses).
    - If the hold slot is empty, move the current shape into hold and pop the queue as a normal spawn, including REFILL.
  - Hold is re-armed by the next spawn_req.
  - hold_valid resets to 0.
- Without the macro, these ports and this logic do not exist.

Test Plan:
- Reset release with PREVIEW=3 → spawn_ready rises within 21 cycles. The preview holds 3 distinct shapes in 0..6. All outputs read 0 before the first spawn.
- 14 back-to-back spawns with top_rows=0 → each consecutive group of 7 shapes is a permutation of 0..6. spawn_valid follows each accepted spawn_req by exactly 1 cycle.
- Spawn of shape 0, SPAWN_X=8 → x=8,9,10,11; y=0,0,0,0; orientation=0. Shape 6 → x=9,10,11,10; y=1,1,1,0.
- top_rows bit 1*20+9 set and shape 1 spawned (SPAWN_X=8) → game_over=1 on the spawn_valid cycle. Later spawn_req pulses give no spawn_valid, and spawn_ready stays 0.
- spawn_req held high during REFILL → no extra spawn. Exactly one spawn_valid per READY acceptance.
- Reset_n pulsed low mid-REFILL → outputs 0 asynchronously. After release, the first preview matches the fresh-seed sequence from the first test.

Source files
------------

// File: rtl/piece_spawner.sv
// piece_spawner: 7-bag piece generator with preview queue, registered spawn cells and top-out check.
// Optional hold slot is compiled in when HOLD_SLOT_EN is defined.
module piece_spawner #(
    parameter int          BOARD_W   = 20,
    parameter int          Y_W       = 6,
    parameter int          SPAWN_X   = 8,
    parameter int          PREVIEW   = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         X_W       = $clog2(BOARD_W)
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 spawn_req,
    input  logic [3*BOARD_W-1:0] top_rows,
`ifdef HOLD_SLOT_EN
    input  logic                 hold_req,
    output logic [2:0]           hold_shape,
    output logic                 hold_valid,
`endif
    output logic                 spawn_ready,
    output logic                 spawn_valid,
    output logic [2:0]           shape,
    output logic [1:0]           orientation,
    output logic [X_W-1:0]       x0,
    output logic [X_W-1:0]       x1,
    output logic [X_W-1:0]       x2,
    output logic [X_W-1:0]       x3,
    output logic [Y_W-1:0]       y0,
    output logic [Y_W-1:0]       y1,
    output logic [Y_W-1:0]       y2,
    output logic [Y_W-1:0]       y3,
    output logic [3*PREVIEW-1:0] preview,
    output logic                 game_over
);

    localparam int QW = 3 * PREVIEW;

    typedef enum logic [2:0] {S_FILL, S_READY, S_CHECK, S_REFILL, S_OVER} state_t;

    state_t             state, state_nx;
    logic [15:0]        lfsr;
    logic [6:0]         bag, bag_set;
    logic [2:0]         cand, draw_cand;
    logic               probing, drawing, draw_used, push;
    logic [QW-1:0]      qv;
    logic [2:0]         cnt;
    logic               pop, load, hit, refill_pend;
    logic [2:0]         ld_shape;
    logic [7:0]         dxs, dys;
    logic [BOARD_W-1:0] rows [4];

`ifdef HOLD_SLOT_EN
    logic hold_armed, do_spawn, do_hold, swap;
`else
    assign refill_pend = 1'b1;
`endif

    assign spawn_ready = (state == S_READY);
    assign spawn_valid = (state == S_CHECK);
    assign game_over   = (state == S_OVER) || ((state == S_CHECK) && hit);
    assign preview     = qv;

    // A probe either lands on a free shape (push) or walks cand forward next cycle.
    always_comb begin
        drawing   = (state == S_FILL) || (state == S_REFILL);
        draw_cand = probing ? cand : ((lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0]);
        draw_used = bag[draw_cand];
        push      = drawing && !draw_used;
        bag_set   = bag | (7'd1 << draw_cand);
    end

    always_comb begin
        rows[0] = top_rows[BOARD_W-1:0];
        rows[1] = top_rows[2*BOARD_W-1:BOARD_W];
        rows[2] = top_rows[3*BOARD_W-1:2*BOARD_W];
        rows[3] = '0;
        hit = rows[y0[1:0]][x0] | rows[y1[1:0]][x1] | rows[y2[1:0]][x2] | rows[y3[1:0]][x3];
    end

    // Cell offsets packed {c3,c2,c1,c0}, two bits per cell.
    always_comb begin
        case (ld_shape)
            3'd0:    begin dxs = 8'b11_10_01_00; dys = 8'b00_00_00_00; end
            3'd1:    begin dxs = 8'b10_01_10_01; dys = 8'b01_01_00_00; end
            3'd2:    begin dxs = 8'b10_01_01_01; dys = 8'b10_10_01_00; end
            3'd3:    begin dxs = 8'b01_10_10_10; dys = 8'b10_10_01_00; end
            3'd4:    begin dxs = 8'b01_10_10_11; dys = 8'b01_01_00_00; end
            3'd5:    begin dxs = 8'b11_10_10_01; dys = 8'b01_01_00_00; end
            3'd6:    begin dxs = 8'b10_11_10_01; dys = 8'b00_01_01_01; end
            default: begin dxs = '0;           dys = '0;           end
        endcase
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        load     = 1'b0;
        ld_shape = qv[2:0];
`ifdef HOLD_SLOT_EN
        do_spawn = 1'b0;
        do_hold  = 1'b0;
        swap     = 1'b0;
`endif
        case (state)
            S_FILL:   if (push && (cnt == 3'(PREVIEW - 1))) state_nx = S_READY;
            S_READY: begin
`ifdef HOLD_SLOT_EN
                if (spawn_req) begin
                    do_spawn = 1'b1;
                    pop      = 1'b1;
                end else if (hold_req && hold_armed) begin
                    do_hold = 1'b1;
                    pop     = !hold_valid;
                    swap    = hold_valid;
                    if (hold_valid) ld_shape = hold_shape;
                end
                load = pop || swap;
`else
                pop  = spawn_req;
                load = spawn_req;
`endif
                if (load) state_nx = S_CHECK;
            end
            S_CHECK:  state_nx = hit ? S_OVER : (refill_pend ? S_REFILL : S_READY);
            S_REFILL: if (push) state_nx = S_READY;
            S_OVER:   state_nx = S_OVER;
            default:  state_nx = S_FILL;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_FILL;
            lfsr        <= LFSR_SEED;
            bag         <= '0;
            cand        <= '0;
            probing     <= 1'b0;
            qv          <= '0;
            cnt         <= '0;
            shape       <= '0;
            orientation <= '0;
            x0 <= '0; x1 <= '0; x2 <= '0; x3 <= '0;
            y0 <= '0; y1 <= '0; y2 <= '0; y3 <= '0;
        end else begin
            state <= state_nx;
            // Fibonacci taps 16,14,13,11
            lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (drawing) begin
                if (draw_used) begin
                    cand    <= (draw_cand == 3'd6) ? 3'd0 : draw_cand + 3'd1;
                    probing <= 1'b1;
                end else begin
                    probing <= 1'b0;
                    bag     <= (bag_set == 7'h7F) ? 7'h00 : bag_set;
                    qv      <= qv | (QW'(draw_cand) << (3 * cnt));
                    cnt     <= cnt + 3'd1;
                end
            end
            if (pop) begin
                qv  <= qv >> 3;
                cnt <= cnt - 3'd1;
            end
            if (load) begin
                shape       <= ld_shape;
                orientation <= '0;
                x0 <= X_W'(SPAWN_X) + X_W'(dxs[1:0]);
                x1 <= X_W'(SPAWN_X) + X_W'(dxs[3:2]);
                x2 <= X_W'(SPAWN_X) + X_W'(dxs[5:4]);
                x3 <= X_W'(SPAWN_X) + X_W'(dxs[7:6]);
                y0 <= Y_W'(dys[1:0]);
                y1 <= Y_W'(dys[3:2]);
                y2 <= Y_W'(dys[5:4]);
                y3 <= Y_W'(dys[7:6]);
            end
        end
    end

`ifdef HOLD_SLOT_EN
    // A swap reissues coordinates without popping, so CHECK must skip REFILL.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_shape  <= '0;
            hold_valid  <= 1'b0;
            hold_armed  <= 1'b0;
            refill_pend <= 1'b0;
        end else begin
            if (load)     refill_pend <= pop;
            if (do_spawn) hold_armed  <= 1'b1;
            if (do_hold) begin
                hold_armed <= 1'b0;
                hold_shape <= shape;
                hold_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_piece_spawner.sv
// Self-checking bench for piece_spawner: coordinate table, bag permutations, latency, top-out, reset.
module tb_piece_spawner;

    localparam int BOARD_W = 20;
    localparam int Y_W     = 6;
    localparam int PREVIEW = 3;
    localparam int X_W     = 5;

    logic                 Clk = 1'b0;
    logic                 Reset_n;
    logic                 spawn_req;
    logic [3*BOARD_W-1:0] top_rows;
    logic                 spawn_ready, spawn_valid, game_over;
    logic [2:0]           shape;
    logic [1:0]           orientation;
    logic [X_W-1:0]       x0, x1, x2, x3;
    logic [Y_W-1:0]       y0, y1, y2, y3;
    logic [3*PREVIEW-1:0] preview;

    piece_spawner #(
        .BOARD_W(20), .Y_W(6), .SPAWN_X(8), .PREVIEW(3), .LFSR_SEED(16'hACE1)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .spawn_req(spawn_req), .top_rows(top_rows),
        .spawn_ready(spawn_ready), .spawn_valid(spawn_valid), .shape(shape),
        .orientation(orientation),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .preview(preview), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int x0, x1, x2, x3, y0, y1, y2, y3;
    } spawn_vec_t;

    spawn_vec_t tbl [7];
    int         checks   = 0;
    int         failures = 0;
    logic [8:0] first_preview;
    logic [2:0] seq [14];

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic cell_hit(input logic [2:0] s);
        cell_hit = top_rows[tbl[s].y0*BOARD_W + tbl[s].x0] | top_rows[tbl[s].y1*BOARD_W + tbl[s].x1] |
                   top_rows[tbl[s].y2*BOARD_W + tbl[s].x2] | top_rows[tbl[s].y3*BOARD_W + tbl[s].x3];
    endfunction

    task automatic check_zero_piece(input string tag);
        check({tag, "_shape"}, shape, 0);
        check({tag, "_orient"}, orientation, 0);
        check({tag, "_x"}, {x0, x1, x2, x3}, 0);
        check({tag, "_y"}, {y0, y1, y2, y3}, 0);
        check({tag, "_valid"}, spawn_valid, 0);
        check({tag, "_game_over"}, game_over, 0);
    endtask

    task automatic wait_ready_after_reset(input string tag);
        int cyc;
        cyc = 0;
        for (int i = 1; i <= 30; i++) begin
            tick;
            cyc = i;
            if (spawn_ready) break;
        end
        check({tag, "_ready_within_21"}, (spawn_ready && cyc <= 21), 1);
    endtask

    task automatic do_spawn(output logic [2:0] s);
        logic [8:0] pv;
        logic       exp_go;
        s = 3'd0;
        for (int i = 0; i < 40; i++) begin
            if (spawn_ready) break;
            tick;
        end
        check("spawn_ready_wait", spawn_ready, 1);
        if (!spawn_ready) return;
        pv = preview;
        check("valid_before_accept", spawn_valid, 0);
        spawn_req = 1'b1;
        tick;
        spawn_req = 1'b0;
        s = pv[2:0];
        exp_go = cell_hit(s);
        check("spawn_valid_n_plus_1", spawn_valid, 1);
        check("ready_low_in_check", spawn_ready, 0);
        check("shape_is_queue_head", shape, pv[2:0]);
        check("orientation", orientation, 0);
        check("x0", x0, tbl[s].x0);
        check("x1", x1, tbl[s].x1);
        check("x2", x2, tbl[s].x2);
        check("x3", x3, tbl[s].x3);
        check("y0", y0, tbl[s].y0);
        check("y1", y1, tbl[s].y1);
        check("y2", y2, tbl[s].y2);
        check("y3", y3, tbl[s].y3);
        check("preview_shift", preview[5:0], pv[8:3]);
        check("preview_tail_empty", preview[8:6], 0);
        check("game_over_on_valid", game_over, exp_go);
        tick;
        check("valid_one_cycle", spawn_valid, 0);
        check("game_over_after", game_over, exp_go);
        check("coords_held", {x0, x1, x2, x3}, {X_W'(tbl[s].x0), X_W'(tbl[s].x1), X_W'(tbl[s].x2), X_W'(tbl[s].x3)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] s;
        logic [2:0] p0, p1, p2;
        logic [6:0] mask;
        logic       prev_ready, go_seen;
        int         accepts;

        // SPAWN_X = 8: hand-computed absolute cells per shape
        tbl[0] = '{8, 9, 10, 11, 0, 0, 0, 0};
        tbl[1] = '{9, 10, 9, 10, 0, 0, 1, 1};
        tbl[2] = '{9, 9, 9, 10, 0, 1, 2, 2};
        tbl[3] = '{10, 10, 10, 9, 0, 1, 2, 2};
        tbl[4] = '{11, 10, 10, 9, 0, 0, 1, 1};
        tbl[5] = '{9, 10, 10, 11, 0, 0, 1, 1};
        tbl[6] = '{9, 10, 11, 10, 1, 1, 1, 0};

        Reset_n   = 1'b0;
        spawn_req = 1'b0;
        top_rows  = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_zero_piece("reset");
        check("reset_preview", preview, 0);
        check("reset_ready", spawn_ready, 0);

        @(negedge Clk);
        Reset_n = 1'b1;
        wait_ready_after_reset("first");
        first_preview = preview;
        p0 = preview[2:0];
        p1 = preview[5:3];
        p2 = preview[8:6];
        check("preview_range", (p0 <= 6) && (p1 <= 6) && (p2 <= 6), 1);
        check("preview_distinct", (p0 != p1) && (p0 != p2) && (p1 != p2), 1);
        check_zero_piece("pre_spawn");

        for (int i = 0; i < 14; i++) begin
            do_spawn(s);
            seq[i] = s;
        end
        for (int g = 0; g < 2; g++) begin
            mask = '0;
            for (int k = 0; k < 7; k++) mask = mask | (7'd1 << seq[g*7 + k]);
            check("bag_permutation", mask, 7'h7F);
        end

        // Request held high: every spawn_valid must follow a READY cycle, and only those.
        for (int i = 0; i < 40; i++) begin
            if (spawn_ready) break;
            tick;
        end
        spawn_req  = 1'b1;
        prev_ready = spawn_ready;
        accepts    = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (prev_ready) accepts++;
            check("held_valid_tracks_accept", spawn_valid, prev_ready);
            prev_ready = spawn_ready;
        end
        spawn_req = 1'b0;
        check("held_accepts", accepts >= 4, 1);

        // Reset asserted while REFILL is drawing
        do_spawn(s);
        check("in_refill_not_ready", spawn_ready, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        check_zero_piece("async_reset");
        check("async_reset_preview", preview, 0);
        check("async_reset_ready", spawn_ready, 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        wait_ready_after_reset("second");
        check("reseed_preview_repeats", preview, first_preview);

        // Top-out: cell (9,1) occupied; shapes 1,2,4,6 cover it
        top_rows = '0;
        top_rows[1*BOARD_W + 9] = 1'b1;
        go_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            do_spawn(s);
            if (cell_hit(s)) begin
                go_seen = 1'b1;
                break;
            end
        end
        check("game_over_reached", go_seen, 1);
        if (go_seen) begin
            for (int i = 0; i < 10; i++) begin
                spawn_req = (i % 2 == 0);
                tick;
                check("over_no_valid", spawn_valid, 0);
                check("over_not_ready", spawn_ready, 0);
                check("over_sticky", game_over, 1);
            end
            spawn_req = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
